// File: rtl/led_arbiter.sv
// Time-sliced round-robin arbiter sharing six active-low LEDs between three
// pattern sources; each owner keeps the LEDs for at least one slice.
module led_arbiter #(
    parameter int SLICE_CYCLES = 13500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [5:0] data0,
    input  logic [5:0] data1,
    input  logic [5:0] data2,
    output logic [2:0] grant,
    output logic       active,
    output logic [5:0] led
);

    localparam int CW = $clog2(SLICE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(SLICE_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    grant_q, grant_d;
    logic          active_q, active_d;
    logic [1:0]    last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    winner_s;
    logic          others_s;
    logic          owner_req_s;

    function automatic logic [1:0] rr_inc(input logic [1:0] idx);
        rr_inc = (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Search order last+1, last+2, last: the first requesting index wins.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] first;
        logic [1:0] second;
        first  = rr_inc(last);
        second = rr_inc(first);
        if (r[first]) begin
            rr_pick = first;
        end else if (r[second]) begin
            rr_pick = second;
        end else begin
            rr_pick = last;
        end
    endfunction

    function automatic logic [2:0] one_hot(input logic [1:0] idx);
        one_hot = 3'b001 << idx;
    endfunction

    // Winner selection and owner status, evaluated every cycle.
    always_comb begin
        winner_s    = rr_pick(req, last_q);
        others_s    = |(req & ~grant_q);
        owner_req_s = |(req & grant_q);
    end

    // Next-state logic; in HOLD, last_q always equals the current owner.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        active_d = active_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (req != 3'b000) begin
                    state_d  = HOLD;
                    grant_d  = one_hot(winner_s);
                    active_d = 1'b1;
                    last_d   = winner_s;
                    cnt_d    = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (!owner_req_s) begin
                    if (others_s) begin
                        grant_d  = one_hot(winner_s);
                        last_d   = winner_s;
                        cnt_d    = '0;
                    end else begin
                        state_d  = IDLE;
                        grant_d  = 3'b000;
                        active_d = 1'b0;
                        cnt_d    = '0;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    if (others_s) begin
                        grant_d = one_hot(winner_s);
                        last_d  = winner_s;
                    end else begin
                        grant_d = grant_q;
                    end
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                grant_d  = 3'b000;
                active_d = 1'b0;
                last_d   = 2'd2;
                cnt_d    = '0;
            end
        endcase
    end

    // State registers with synchronous reset; pointer 2 makes source 0 first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= 3'b000;
            active_q <= 1'b0;
            last_q   <= 2'd2;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            active_q <= active_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
        end
    end

    // LED mux follows the owner's pattern in the same cycle it changes.
    always_comb begin
        led = 6'h3F;
        if (active_q) begin
            case (grant_q)
                3'b001:  led = ~data0;
                3'b010:  led = ~data1;
                3'b100:  led = ~data2;
                default: led = 6'h3F;
            endcase
        end else begin
            led = 6'h3F;
        end
    end

    assign grant  = grant_q;
    assign active = active_q;

endmodule

// File: tb/tb_led_arbiter.sv
// Directed bench for led_arbiter with SLICE_CYCLES=4 and hand-computed grants.
module tb_led_arbiter;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic [5:0] data0, data1, data2;
    logic [2:0] grant;
    logic       active;
    logic [5:0] led;

    int errors = 0;
    int checks = 0;

    led_arbiter #(.SLICE_CYCLES(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .data0  (data0),
        .data1  (data1),
        .data2  (data2),
        .grant  (grant),
        .active (active),
        .led    (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then check that grant is never multi-hot.
    task automatic step();
        @(posedge clk);
        #1;
        check_eq("onehot0", {7'd0, $onehot0(grant)}, 8'd1);
    endtask

    task automatic expect_grant(input string tag, input logic [2:0] g, input logic [5:0] l);
        check_eq(tag, {5'd0, grant}, {5'd0, g});
        check_eq({tag, "_active"}, {7'd0, active}, {7'd0, (g != 3'b000)});
        check_eq({tag, "_led"}, {2'd0, led}, {2'd0, l});
    endtask

    initial begin
        rst   = 1'b1;
        req   = 3'b111;
        data0 = 6'h01;
        data1 = 6'h15;
        data2 = 6'h30;

        // 1. reset with all requests high
        step();
        expect_grant("rst_a", 3'b000, 6'h3F);
        step();
        expect_grant("rst_b", 3'b000, 6'h3F);
        rst = 1'b0;
        step();
        expect_grant("first_grant", 3'b001, 6'h3E);

        // 2. rotation 001 x4, 010 x4, 100 x4, 001
        for (int i = 0; i < 3; i++) begin
            step();
            expect_grant("rot0", 3'b001, 6'h3E);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            expect_grant("rot1", 3'b010, 6'h2A);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            expect_grant("rot2", 3'b100, 6'h0F);
        end
        step();
        expect_grant("rot_wrap", 3'b001, 6'h3E);

        // 3. single requester with renewals
        req = 3'b000;
        step();
        expect_grant("to_idle", 3'b000, 6'h3F);
        req = 3'b010;
        for (int i = 0; i < 12; i++) begin
            step();
            expect_grant("single", 3'b010, 6'h2A);
        end
        data1 = 6'h3C;
        #1;
        check_eq("led_follow", {2'd0, led}, 8'h03);
        data1 = 6'h15;
        req = 3'b000;
        step();
        expect_grant("single_drop", 3'b000, 6'h3F);

        // 4. early release by owner 0 at cnt=1
        req = 3'b001;
        step();
        expect_grant("early_own", 3'b001, 6'h3E);
        step();
        expect_grant("early_cnt1", 3'b001, 6'h3E);
        req = 3'b100;
        step();
        expect_grant("early_sw", 3'b100, 6'h0F);
        req = 3'b101;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_grant("early_slice", 3'b100, 6'h0F);
        end
        step();
        expect_grant("early_next", 3'b001, 6'h3E);

        // 5. expiry and owner drop on the same edge
        req = 3'b011;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_grant("coll_hold", 3'b001, 6'h3E);
        end
        req = 3'b010;
        step();
        expect_grant("coll_sw", 3'b010, 6'h2A);

        // 6. reset while source 2 owns the LEDs
        req = 3'b100;
        step();
        expect_grant("pre_rst", 3'b100, 6'h0F);
        rst = 1'b1;
        req = 3'b111;
        step();
        expect_grant("mid_rst", 3'b000, 6'h3F);
        rst = 1'b0;
        step();
        expect_grant("post_rst", 3'b001, 6'h3E);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_arbiter.md
# led_arbiter

Time-sliced round-robin arbiter that shares the board's 6 active-low LEDs between three pattern sources (e.g. the LED counter, a status monitor, an error indicator). Each requester gets the LEDs for at least one slice while others wait, and each drives its own 6-bit pattern. The block sits between the pattern generators and the top-level `led` pins; LEDs are off whenever nobody holds a grant.

## Interface
- `SLICE_CYCLES`, default 13500000: minimum grant length in `clk` cycles (0.5 s at 27 MHz); legal range ≥ 2.
- `clk`  in  1  system clock (27 MHz on board).
- `rst`  in  1  synchronous, active-high reset; sampled on the rising edge of `clk`.
- `req`  in  3  request per source; level-sensitive and held while the source wants the LEDs.
- `data0`, `data1`, `data2`  in  6 each  active-high LED pattern of each source (1 = lit).
- `grant`  out  3  one-hot grant, all-zero when idle; registered.
- `active`  out  1  OR of `grant`; registered.
- `led`  out  6  board LED pins, active-low (0 = lit).

## Operation
- States:
  - IDLE: `grant` = 0.
  - HOLD: exactly one `grant` bit is set. The owner index is g.
- Round-robin pointer `last` (2 bits):
  - Holds the most recent owner.
  - Search order is last+1, last+2, last (mod 3).
  - The first requesting index in that order wins.
- Slice counter `cnt`:
  - Width is $clog2(SLICE_CYCLES).
  - Loads 0 on every new or renewed grant, then increments by 1 per cycle in HOLD.
  - Never wraps: it is reloaded at SLICE_CYCLES-1.
- IDLE transitions:
  - If `req` ≠ 0: go to HOLD with grant = winner, `last` = winner, `cnt` = 0.
  - Otherwise stay in IDLE.
- HOLD transitions, evaluated in priority order:
  1. Owner drops its request (`req[g]` = 0): release immediately, without waiting for the slice to end.
     - If another `req` bit is set: grant the winner at the next edge (no idle gap), `cnt` = 0.
     - Otherwise go to IDLE.
  2. `cnt` == SLICE_CYCLES-1 and another requester is pending: switch to the winner searched from g+1, `cnt` = 0.
  3. `cnt` == SLICE_CYCLES-1 and only the owner is requesting: renew. Grant is unchanged, `cnt` = 0.
  4. Otherwise: `cnt` = `cnt` + 1.
- `led` is combinational from the registered grant:
  - `led` = ~data_g when `active`.
  - `led` = 6'b111111 when idle.
  - A `data` change of the owning source appears on `led` in the same cycle.
- `req` of a non-owner has no effect mid-slice: no pre-emption and no priority inversion.

## Timing
- Reset values: `grant` = 0, `active` = 0, `led` = 6'b111111, `cnt` = 0, `last` = 2 (first search starts at source 0), state = IDLE.
- Reset asserted mid-grant: `grant` and `active` clear at that edge, and `led` is all-off in the following cycle. The pointer returns to 2.
- Grant latency from IDLE: `req` high at edge t, `grant` high after edge t+1 (1 cycle).
- Release latency: `req[g]` low sampled at an edge, so `grant[g]` is low after that edge.
- Full uncontested slice: `grant` is stable for exactly SLICE_CYCLES cycles before a switch.
- Simultaneous slice expiry and owner drop: the drop rule wins (treated as a release; the pointer advances past g).
- Simultaneous new requests at IDLE: round-robin order decides; there is no fixed priority.
- `grant` is always one-hot or zero and never has two bits set, including at switch edges.

## Test plan
1. Reset with SLICE_CYCLES=4:
   - Stimulus: `rst` held 2 cycles; `req` = 3'b111 during reset.
   - Required response: `grant` = 0 and `led` = 6'h3F during reset. After release, `grant` = 3'b001 one cycle later.
2. Rotation with `req` = 3'b111 held, SLICE_CYCLES=4:
   - Required grant sequence: 001 ×4 cycles, 010 ×4, 100 ×4, 001.
   - `led` = ~`data_g` in each window (e.g. `data1` = 6'h15 gives `led` = 6'h2A).
3. Single requester:
   - Stimulus: `req` = 3'b010 for 12 cycles.
   - Required response: `grant` stays 010 across renewals with no glitch. Drop `req` → `grant` = 0 and `led` = 6'h3F next cycle.
4. Early release:
   - Stimulus: owner 0 drops `req` at `cnt` = 1 while `req[2]` = 1.
   - Required response: `grant` becomes 100 at the next edge, with a full 4-cycle slice following.
5. Expiry/drop collision:
   - Stimulus: `req[0]` falls exactly at `cnt` = 3 with `req[1]` = 1.
   - Required response: `grant` becomes 010. No cycle has two grant bits set.
6. Reset mid-slice:
   - Stimulus: `rst` pulsed while `grant` = 100.
   - Required response: `grant` = 0, then `grant` = 001 with all requests high (pointer reset).
